// File: rtl/gray_to_binary_decoder_pkg.sv
// Shared Gray-code helpers for the Gray encoder/decoder pair.
//
// Contents
//   MAX_W         widest Gray word the helpers handle; callers zero-extend
//                 narrower words and keep only their low bits
//   CNT_W         width of a popcount result over MAX_W bits
//   step_class_e  classification of the step between two Gray samples
//   gray2bin      Gray -> binary (prefix XOR from the MSB down)
//   bin2gray      binary -> Gray (b ^ (b >> 1)), used by the encoder
//   popcount      number of set bits
//
// Zero-extension is harmless for both conversions.
// - gray2bin: each binary bit is the XOR of the Gray bits at and above it,
//   and the extra bits are all zero.
// - bin2gray: the extra bits shift in as zero.
package gray_to_binary_decoder_pkg;

    localparam int unsigned MAX_W = 32;
    localparam int unsigned CNT_W = 6;

    typedef enum logic [1:0] {
        STEP_SAME   = 2'd0,  // identical Gray word
        STEP_SINGLE = 2'd1,  // exactly one bit changed
        STEP_JUMP   = 2'd2   // two or more bits changed
    } step_class_e;

    function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] g);
        logic [MAX_W-1:0] b;
        b[MAX_W-1] = g[MAX_W-1];
        for (int i = int'(MAX_W) - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] b);
        return b ^ {1'b0, b[MAX_W-1:1]};
    endfunction

    function automatic logic [CNT_W-1:0] popcount(input logic [MAX_W-1:0] v);
        logic [CNT_W-1:0] c;
        c = {CNT_W{1'b0}};
        for (int i = 0; i < int'(MAX_W); i++) begin
            c = c + {{(CNT_W-1){1'b0}}, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/gray_to_binary_decoder_if.sv
// Stream bundle between a Gray sample source, the decoder and its consumer.
//
// master : the environment side. It drives in_valid, gray and out_ready,
//          and observes the results.
// slave  : the decoder side. It drives in_ready, the result registers
//          and err_cnt.
interface gray_to_binary_decoder_if #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned ERR_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] gray;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] binary;
    logic             dir_up;
    logic             dir_down;
    logic             repeat_flag;
    logic             step_err;
    logic [ERR_W-1:0] err_cnt;

    modport master (
        output in_valid, gray, out_ready,
        input  in_ready, out_valid, binary, dir_up, dir_down,
               repeat_flag, step_err, err_cnt
    );

    modport slave (
        input  in_valid, gray, out_ready,
        output in_ready, out_valid, binary, dir_up, dir_down,
               repeat_flag, step_err, err_cnt
    );
endinterface

// File: rtl/gray_to_binary_decoder_step_checker.sv
// Combinational step classifier for two consecutive Gray samples.
//
// Ports
//   gray_i        current Gray sample
//   prev_gray_i   previously accepted Gray sample
//   binary_o      binary value of gray_i
//   step_class_o  SAME / SINGLE / JUMP, from the Hamming distance
//   dir_up_o      single step and the value moved by +1 (mod 2^WIDTH)
//   dir_down_o    single step and the value moved by -1 (mod 2^WIDTH)
//
// WIDTH must lie in 2 .. MAX_W-1.
module gray_step_checker
    import gray_to_binary_decoder_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] gray_i,
    input  logic [WIDTH-1:0] prev_gray_i,
    output logic [WIDTH-1:0] binary_o,
    output step_class_e      step_class_o,
    output logic             dir_up_o,
    output logic             dir_down_o
);

    logic [MAX_W-1:0] gray_ext_s;
    logic [MAX_W-1:0] prev_ext_s;
    logic [MAX_W-1:0] bin_ext_s;
    logic [MAX_W-1:0] prev_bin_ext_s;
    logic [WIDTH-1:0] delta_s;
    logic [CNT_W-1:0] dist_s;
    logic             unused_hi_s;

    // Zero-extend both samples to the helper width
    always_comb begin
        gray_ext_s              = {MAX_W{1'b0}};
        prev_ext_s              = {MAX_W{1'b0}};
        gray_ext_s[WIDTH-1:0]   = gray_i;
        prev_ext_s[WIDTH-1:0]   = prev_gray_i;
    end

    assign bin_ext_s      = gray2bin(gray_ext_s);
    assign prev_bin_ext_s = gray2bin(prev_ext_s);
    assign binary_o       = bin_ext_s[WIDTH-1:0];
    // Subtraction in WIDTH bits gives the modular step, so wrap-around
    // (max->0, 0->max) appears as +1 / -1.
    assign delta_s        = bin_ext_s[WIDTH-1:0] - prev_bin_ext_s[WIDTH-1:0];
    assign dist_s         = popcount(gray_ext_s ^ prev_ext_s);
    // The upper bits are zero by construction.
    assign unused_hi_s    = ^{bin_ext_s[MAX_W-1:WIDTH], prev_bin_ext_s[MAX_W-1:WIDTH]};

    // Classify the step by Hamming distance and derive the direction
    always_comb begin
        step_class_o = STEP_JUMP;
        dir_up_o     = 1'b0;
        dir_down_o   = 1'b0;
        if (dist_s == {CNT_W{1'b0}}) begin
            step_class_o = STEP_SAME;
        end else if (dist_s == {{(CNT_W-1){1'b0}}, 1'b1}) begin
            step_class_o = STEP_SINGLE;
            dir_up_o     = (delta_s == {{(WIDTH-1){1'b0}}, 1'b1});
            dir_down_o   = (delta_s == {WIDTH{1'b1}});
        end else begin
            step_class_o = STEP_JUMP;
        end
    end

endmodule

// File: rtl/gray_to_binary_decoder.sv
// Registered Gray-to-binary decoder with valid/ready flow control and
// step checking.
//
// Ports
//   clk    rising-edge clock
//   reset  synchronous, active-high; clears all state, including a held
//          result that has not been consumed
//   bus    slave side of gray_to_binary_decoder_if
//     in_valid / in_ready / gray     sample input; in_ready is
//                                    !out_valid || out_ready
//     out_valid / out_ready          one-entry result register
//     binary, dir_up, dir_down,      result, one cycle after accept,
//     repeat_flag, step_err          qualified by out_valid
//     err_cnt                        saturating count of step_err
//                                    results; a status output that does
//                                    not depend on out_valid
module gray_to_binary_decoder
    import gray_to_binary_decoder_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned ERR_W = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    gray_to_binary_decoder_if.slave  bus
);

    logic             out_valid_q,   out_valid_d;
    logic [WIDTH-1:0] binary_q,      binary_d;
    logic             dir_up_q,      dir_up_d;
    logic             dir_down_q,    dir_down_d;
    logic             repeat_q,      repeat_d;
    logic             step_err_q,    step_err_d;
    logic [ERR_W-1:0] err_cnt_q,     err_cnt_d;
    logic             have_prev_q,   have_prev_d;
    logic [WIDTH-1:0] prev_gray_q,   prev_gray_d;

    logic             in_ready_s;
    logic             accept_s;
    logic             consume_s;
    logic [WIDTH-1:0] conv_bin_s;
    step_class_e      step_class_s;
    logic             chk_up_s;
    logic             chk_down_s;

    // The output register can take a new result when it is empty or is
    // being drained this cycle. This allows accept and consume in the
    // same cycle, so there is no bubble.
    assign in_ready_s = !out_valid_q || bus.out_ready;
    assign accept_s   = bus.in_valid && in_ready_s;
    assign consume_s  = out_valid_q && bus.out_ready;

    gray_step_checker #(
        .WIDTH (WIDTH)
    ) u_step_checker (
        .gray_i       (bus.gray),
        .prev_gray_i  (prev_gray_q),
        .binary_o     (conv_bin_s),
        .step_class_o (step_class_s),
        .dir_up_o     (chk_up_s),
        .dir_down_o   (chk_down_s)
    );

    // Next-state: load a new result on accept, drop valid on consume, else hold
    always_comb begin
        out_valid_d = out_valid_q;
        binary_d    = binary_q;
        dir_up_d    = dir_up_q;
        dir_down_d  = dir_down_q;
        repeat_d    = repeat_q;
        step_err_d  = step_err_q;
        err_cnt_d   = err_cnt_q;
        have_prev_d = have_prev_q;
        prev_gray_d = prev_gray_q;
        if (accept_s) begin
            out_valid_d = 1'b1;
            binary_d    = conv_bin_s;
            prev_gray_d = bus.gray;
            have_prev_d = 1'b1;
            if (have_prev_q) begin
                dir_up_d   = chk_up_s;
                dir_down_d = chk_down_s;
                repeat_d   = (step_class_s == STEP_SAME);
                step_err_d = (step_class_s == STEP_JUMP);
                if ((step_class_s == STEP_JUMP) && (err_cnt_q != {ERR_W{1'b1}})) begin
                    err_cnt_d = err_cnt_q + {{(ERR_W-1){1'b0}}, 1'b1};
                end else begin
                    err_cnt_d = err_cnt_q;
                end
            end else begin
                // The first sample after reset has nothing to compare against.
                dir_up_d   = 1'b0;
                dir_down_d = 1'b0;
                repeat_d   = 1'b0;
                step_err_d = 1'b0;
            end
        end else if (consume_s) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            binary_q    <= {WIDTH{1'b0}};
            dir_up_q    <= 1'b0;
            dir_down_q  <= 1'b0;
            repeat_q    <= 1'b0;
            step_err_q  <= 1'b0;
            err_cnt_q   <= {ERR_W{1'b0}};
            have_prev_q <= 1'b0;
            prev_gray_q <= {WIDTH{1'b0}};
        end else begin
            out_valid_q <= out_valid_d;
            binary_q    <= binary_d;
            dir_up_q    <= dir_up_d;
            dir_down_q  <= dir_down_d;
            repeat_q    <= repeat_d;
            step_err_q  <= step_err_d;
            err_cnt_q   <= err_cnt_d;
            have_prev_q <= have_prev_d;
            prev_gray_q <= prev_gray_d;
        end
    end

    assign bus.in_ready    = in_ready_s;
    assign bus.out_valid   = out_valid_q;
    assign bus.binary      = binary_q;
    assign bus.dir_up      = dir_up_q;
    assign bus.dir_down    = dir_down_q;
    assign bus.repeat_flag = repeat_q;
    assign bus.step_err    = step_err_q;
    assign bus.err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_gray_to_binary_decoder.sv
// Self-checking bench for gray_to_binary_decoder (WIDTH=4, ERR_W=8).
// The reference model decodes by searching for the value whose Gray code
// matches. It uses $countones for the Hamming distance and modular integer
// arithmetic for direction.
module tb_gray_to_binary_decoder;

    localparam int W  = 4;
    localparam int EW = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    gray_to_binary_decoder_if #(.WIDTH(W), .ERR_W(EW)) bus();

    gray_to_binary_decoder #(.WIDTH(W), .ERR_W(EW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    // reference model state
    bit m_valid, m_up, m_dn, m_rep, m_err, m_have;
    int m_bin, m_cnt, m_prev;

    function automatic int decode(input int g);
        int r;
        r = 0;
        for (int v = 0; v < 16; v++) begin
            if (((v ^ (v >> 1)) & 15) == g) r = v;
        end
        return r;
    endfunction

    // One clock edge; the model follows the inputs applied before the edge.
    task automatic tick();
        bit rst, acc, cons;
        int g, b, d, diff;
        rst  = reset;
        g    = int'(bus.gray);
        acc  = bus.in_valid && (!m_valid || bus.out_ready);
        cons = m_valid && bus.out_ready;
        @(posedge clk);
        #1;
        if (rst) begin
            m_valid = 0; m_up = 0; m_dn = 0; m_rep = 0; m_err = 0;
            m_have = 0; m_bin = 0; m_cnt = 0; m_prev = 0;
        end else if (acc) begin
            b = decode(g);
            m_up = 0; m_dn = 0; m_rep = 0; m_err = 0;
            if (m_have) begin
                d = $countones(g ^ m_prev);
                if (d == 0) m_rep = 1;
                else if (d == 1) begin
                    diff = (b - decode(m_prev) + 16) % 16;
                    m_up = (diff == 1);
                    m_dn = (diff == 15);
                end else begin
                    m_err = 1;
                    if (m_cnt < 255) m_cnt++;
                end
            end
            m_bin = b; m_valid = 1; m_have = 1; m_prev = g;
        end else if (cons) begin
            m_valid = 0;
        end
    endtask

    task automatic send(input int g, input bit v, input bit ordy);
        bus.gray      = W'(g);
        bus.in_valid  = v;
        bus.out_ready = ordy;
        tick();
    endtask

    task automatic do_reset();
        reset = 1'b1; bus.in_valid = 1'b0; bus.out_ready = 1'b1; bus.gray = '0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        if ({bus.out_valid, bus.binary, bus.dir_up, bus.dir_down, bus.repeat_flag, bus.step_err} !== 9'd0) begin
            errors++; $display("FAIL reset_outputs: got %b want 0", {bus.out_valid, bus.binary, bus.dir_up, bus.dir_down, bus.repeat_flag, bus.step_err});
        end
        checks++;
        if (bus.err_cnt !== 8'd0) begin
            errors++; $display("FAIL reset_err_cnt: got %0d want 0", bus.err_cnt);
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
        end
        checks++;
    endtask

    task automatic test_first_sample();
        do_reset();
        send(6, 1, 1);
        bus.in_valid = 1'b0;
        if ({bus.out_valid, bus.binary, bus.dir_up, bus.dir_down, bus.repeat_flag, bus.step_err} !== {1'b1, 4'b0100, 4'b0000}
            || bus.err_cnt !== 8'd0) begin
            errors++; $display("FAIL first_sample: got v=%b bin=%b flags=%b%b%b%b cnt=%0d want v=1 bin=0100 flags=0000 cnt=0",
                bus.out_valid, bus.binary, bus.dir_up, bus.dir_down, bus.repeat_flag, bus.step_err, bus.err_cnt);
        end
        checks++;
    endtask

    task automatic test_back_to_back();
        int gseq[4] = '{0, 1, 3, 2};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            bus.gray = W'(gseq[i]); bus.in_valid = 1'b1; bus.out_ready = 1'b1;
            #1;
            if (bus.in_ready !== 1'b1) begin
                errors++; $display("FAIL b2b_in_ready[%0d]: got %b want 1", i, bus.in_ready);
            end
            checks++;
            tick();
            if (bus.out_valid !== 1'b1 || bus.binary !== W'(i) || bus.dir_up !== (i > 0)
                || bus.dir_down !== 1'b0 || bus.step_err !== 1'b0) begin
                errors++; $display("FAIL b2b_result[%0d]: got v=%b bin=%0d up=%b dn=%b err=%b want v=1 bin=%0d up=%b dn=0 err=0",
                    i, bus.out_valid, bus.binary, bus.dir_up, bus.dir_down, bus.step_err, i, (i > 0));
            end
            checks++;
        end
    endtask

    task automatic test_step_err();
        do_reset();
        send(2, 1, 1);
        send(7, 1, 1);
        if (bus.step_err !== 1'b1 || bus.binary !== 4'b0101 || bus.err_cnt !== 8'd1
            || bus.dir_up !== 1'b0 || bus.dir_down !== 1'b0 || bus.repeat_flag !== 1'b0) begin
            errors++; $display("FAIL step_err: got err=%b bin=%b cnt=%0d up=%b dn=%b rep=%b want err=1 bin=0101 cnt=1 up=0 dn=0 rep=0",
                bus.step_err, bus.binary, bus.err_cnt, bus.dir_up, bus.dir_down, bus.repeat_flag);
        end
        checks++;
        send(7, 1, 1);
        if (bus.repeat_flag !== 1'b1 || bus.step_err !== 1'b0 || bus.err_cnt !== 8'd1) begin
            errors++; $display("FAIL repeat: got rep=%b err=%b cnt=%0d want rep=1 err=0 cnt=1",
                bus.repeat_flag, bus.step_err, bus.err_cnt);
        end
        checks++;
    endtask

    task automatic test_wrap();
        do_reset();
        send(8, 1, 1);
        send(0, 1, 1);
        if (bus.dir_up !== 1'b1 || bus.dir_down !== 1'b0 || bus.binary !== 4'b0000) begin
            errors++; $display("FAIL wrap_up: got up=%b dn=%b bin=%b want up=1 dn=0 bin=0000", bus.dir_up, bus.dir_down, bus.binary);
        end
        checks++;
        send(8, 1, 1);
        if (bus.dir_down !== 1'b1 || bus.dir_up !== 1'b0 || bus.binary !== 4'b1111) begin
            errors++; $display("FAIL wrap_down: got up=%b dn=%b bin=%b want up=0 dn=1 bin=1111", bus.dir_up, bus.dir_down, bus.binary);
        end
        checks++;
    endtask

    task automatic test_backpressure();
        do_reset();
        send(1, 1, 0);
        for (int i = 0; i < 5; i++) begin
            send(3, 1, 0);
            if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.binary !== 4'd1
                || {bus.dir_up, bus.dir_down, bus.repeat_flag, bus.step_err} !== 4'b0000) begin
                errors++; $display("FAIL bp_hold[%0d]: got rdy=%b v=%b bin=%0d flags=%b%b%b%b want rdy=0 v=1 bin=1 flags=0000",
                    i, bus.in_ready, bus.out_valid, bus.binary, bus.dir_up, bus.dir_down, bus.repeat_flag, bus.step_err);
            end
            checks++;
        end
        send(3, 1, 1);
        if (bus.out_valid !== 1'b1 || bus.binary !== 4'd2 || bus.dir_up !== 1'b1) begin
            errors++; $display("FAIL bp_release: got v=%b bin=%0d up=%b want v=1 bin=2 up=1", bus.out_valid, bus.binary, bus.dir_up);
        end
        checks++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        send(0, 1, 1);
        send(3, 1, 1);
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        tick();
        reset = 1'b1; bus.in_valid = 1'b1; bus.gray = 4'd5;
        tick();
        reset = 1'b0;
        if (bus.out_valid !== 1'b0 || bus.err_cnt !== 8'd0) begin
            errors++; $display("FAIL reset_mid: got v=%b cnt=%0d want v=0 cnt=0", bus.out_valid, bus.err_cnt);
        end
        checks++;
        send(7, 1, 1);
        if (bus.out_valid !== 1'b1 || bus.binary !== 4'd5
            || {bus.dir_up, bus.dir_down, bus.repeat_flag, bus.step_err} !== 4'b0000) begin
            errors++; $display("FAIL reset_mid_first: got v=%b bin=%0d flags=%b%b%b%b want v=1 bin=5 flags=0000",
                bus.out_valid, bus.binary, bus.dir_up, bus.dir_down, bus.repeat_flag, bus.step_err);
        end
        checks++;
    endtask

    task automatic test_saturate();
        int want;
        do_reset();
        send(0, 1, 1);
        for (int i = 0; i < 300; i++) begin
            send((i % 2 == 0) ? 3 : 0, 1, 1);
            want = (i + 1 > 255) ? 255 : i + 1;
            if (bus.step_err !== 1'b1 || bus.err_cnt !== EW'(want)) begin
                errors++; $display("FAIL saturate[%0d]: got err=%b cnt=%0d want err=1 cnt=%0d", i, bus.step_err, bus.err_cnt, want);
            end
            checks++;
        end
    endtask

    task automatic test_random();
        int r, pb, b;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            r  = $urandom_range(0, 9);
            pb = decode(m_prev);
            if (r < 4)      b = (pb + 1) % 16;
            else if (r < 7) b = (pb + 15) % 16;
            else if (r < 8) b = pb;
            else            b = $urandom_range(0, 15);
            bus.gray      = W'(b ^ (b >> 1));
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 2) != 0);
            reset         = ($urandom_range(0, 49) == 0);
            #1;
            if (bus.in_ready !== (!m_valid || bus.out_ready)) begin
                errors++; $display("FAIL rand_in_ready[%0d]: got %b want %b", i, bus.in_ready, (!m_valid || bus.out_ready));
            end
            checks++;
            tick();
            reset = 1'b0;
            if (bus.out_valid !== m_valid || bus.err_cnt !== EW'(m_cnt)
                || (m_valid && {bus.binary, bus.dir_up, bus.dir_down, bus.repeat_flag, bus.step_err}
                               !== {W'(m_bin), m_up, m_dn, m_rep, m_err})) begin
                errors++; $display("FAIL rand_result[%0d]: got v=%b bin=%0d flags=%b%b%b%b cnt=%0d want v=%b bin=%0d flags=%b%b%b%b cnt=%0d",
                    i, bus.out_valid, bus.binary, bus.dir_up, bus.dir_down, bus.repeat_flag, bus.step_err, bus.err_cnt,
                    m_valid, m_bin, m_up, m_dn, m_rep, m_err, m_cnt);
            end
            checks++;
        end
    endtask

    initial begin
        reset = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.gray = '0;
        m_valid = 0; m_up = 0; m_dn = 0; m_rep = 0; m_err = 0; m_have = 0;
        m_bin = 0; m_cnt = 0; m_prev = 0;
        test_reset();
        test_first_sample();
        test_back_to_back();
        test_step_err();
        test_wrap();
        test_backpressure();
        test_reset_mid();
        test_saturate();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
